// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS-subset pipeline front end.
// Holds the fetch FSM state type, the instruction size in bytes, the NOP
// encoding and the default reset PC used by fetch_stage and pc_unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/valid bundle.
//   addr   : byte address of the requested instruction (fetch -> memory)
//   req    : fetch request this cycle                  (fetch -> memory)
//   data   : instruction word                          (memory -> fetch)
//   rvalid : data is valid for addr this cycle         (memory -> fetch)
// master = fetch side, slave = memory side.
interface fetch_stage_if #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned INSTR_W = 32
) ();

    logic [ADDR_W-1:0]  addr;
    logic               req;
    logic [INSTR_W-1:0] data;
    logic               rvalid;

    modport master (
        output addr,
        output req,
        input  data,
        input  rvalid
    );

    modport slave (
        input  addr,
        input  req,
        output data,
        output rvalid
    );

endinterface

// File: rtl/pc_unit.sv
// PC / nPC register pair for the fetch stage.
// Applies flush, stall, fault-hold, fetch-advance and branch-redirect updates
// in that priority order, and flags a fetch fault for the current PC.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush_i, flush_pc_i : restart request and restart address
//   stall_i             : hold PC/nPC
//   hold_i              : faulting fetch in RUN, hold PC/nPC
//   fire_i              : instruction accepted into IF/ID this cycle
//   br_taken_i          : taken branch/jump from ID
//   br_target_i         : redirect target
//   pc_o                : current PC
//   fault_o             : PC misaligned or above the memory range
module pc_unit
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     ADDR_W   = 9,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    input  logic            stall_i,
    input  logic            hold_i,
    input  logic            fire_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fault_o
);

    localparam logic [PC_W-1:0] Step = PC_W'(INSTR_BYTES);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic [PC_W-1:0] npc_eff;

    assign npc_eff = br_taken_i ? br_target_i : npc_q;

    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (flush_i) begin
            pc_d  = flush_pc_i;
            npc_d = flush_pc_i + Step;
        end else if (stall_i || hold_i) begin
            // ID re-asserts any branch after the stall, so drop it here
        end else if (fire_i) begin
            pc_d  = npc_eff;
            npc_d = npc_eff + Step;
        end else if (br_taken_i) begin
            // Memory wait: park the target in nPC so the delay slot still
            // goes first and the redirect is not lost
            npc_d = br_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + Step;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc_o    = pc_q;
    assign fault_o = (pc_q[1:0] != 2'b00) || (pc_q[PC_W-1:ADDR_W] != '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Drives instruction memory via a req/rvalid handshake, implements branch
// delay slots, absorbs memory waits, ID stalls, redirects and flushes, and
// latches a sticky fault on misaligned or out-of-range PCs.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   imem                  : instruction-memory bundle (master side)
//   stall                 : ID hazard, hold everything
//   br_taken, br_target   : taken branch/jump redirect from ID
//   flush, flush_pc       : exception/restart request
//   ifid_instr/pc/valid   : IF/ID register contents
//   fetch_exc, exc_pc     : sticky fetch fault and faulting PC
//   fetch_count           : instructions delivered to IF/ID (wrapping)
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int unsigned        PC_W     = 32,
    parameter int unsigned        ADDR_W   = 9,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [PC_W-1:0]    RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP      = INSTR_W'(NOP_INSTR),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               fetch_exc,
    output logic [PC_W-1:0]    exc_pc,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               valid_q, valid_d;
    logic               exc_q, exc_d;
    logic [PC_W-1:0]    exc_pc_q, exc_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PC_W-1:0] pc;
    logic            fault;
    logic            run;
    logic            fault_hold;
    logic            fire;

    assign run        = (state_q == StRun);
    assign imem.req   = run && !stall && !fault;
    assign imem.addr  = pc[ADDR_W-1:0];
    assign fire       = imem.req && imem.rvalid;
    assign fault_hold = run && fault;

    pc_unit #(
        .PC_W     (PC_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .stall_i     (stall),
        .hold_i      (fault_hold),
        .fire_i      (fire),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .pc_o        (pc),
        .fault_o     (fault)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (!stall && fault) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase
        if (flush) begin
            state_d = StRun;
        end
    end

    always_comb begin
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        exc_d     = exc_q;
        exc_pc_d  = exc_pc_q;
        count_d   = count_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
            exc_d   = 1'b0;
        end else if (stall) begin
            // hold IF/ID and counter
        end else if (fault_hold) begin
            instr_d  = NOP;
            valid_d  = 1'b0;
            exc_d    = 1'b1;
            exc_pc_d = pc;
        end else if (fire) begin
            instr_d   = imem.data;
            ifid_pc_d = pc;
            valid_d   = 1'b1;
            count_d   = count_q + CNT_W'(1);
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StBoot;
            instr_q   <= NOP;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
            exc_q     <= 1'b0;
            exc_pc_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
            exc_q     <= exc_d;
            exc_pc_q  <= exc_pc_d;
            count_q   <= count_d;
        end
    end

    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = valid_q;
    assign fetch_exc   = exc_q;
    assign exc_pc      = exc_pc_q;
    assign fetch_count = count_q;

endmodule
